// File: rtl/affine_pipeline_stream_pkg.sv
// Shared arithmetic helpers for the affine pipeline: range checks and the
// wrap/clip reduction from the widened sum back to the W-bit data width.
package affine_pkg;

  localparam int SAT_WRAP = 0;
  localparam int SAT_CLIP = 1;

  // Widest supported W; the helpers operate on a 2*MAX_W+1 sum so one
  // set of functions serves every stage width up to MAX_W.
  localparam int MAX_W = 32;
  localparam int SUM_W = 2 * MAX_W + 1;

  typedef logic signed [SUM_W-1:0] wide_t;

  function automatic wide_t max_of(input int w);
    return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t min_of(input int w);
    return -(wide_t'(1) <<< (w - 1));
  endfunction

  function automatic logic out_of_range(input wide_t s, input int w);
    return (s > max_of(w)) || (s < min_of(w));
  endfunction

  // Callers truncate the result to w bits; in wrap mode that yields s[w-1:0].
  function automatic wide_t sat_to_w(input wide_t s, input int w, input logic clip);
    if (clip && (s > max_of(w))) return max_of(w);
    if (clip && (s < min_of(w))) return min_of(w);
    return s;
  endfunction

endpackage

// File: rtl/affine_pipeline_stream_if.sv
// Valid/ready stream bundle for the affine pipeline, input and output sides
// plus the sticky overflow flag.
interface affine_pipeline_stream_if #(
    parameter int W = 16
) ();

    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] X;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] Y;
    logic                ovf;

    modport master (
        output in_valid, X, out_ready,
        input  in_ready, out_valid, Y, ovf
    );

    modport slave (
        input  in_valid, X, out_ready,
        output in_ready, out_valid, Y, ovf
    );

endinterface

// File: rtl/affine_pipeline_stream_stage.sv
// One registered affine stage: data <= f(src) = src*K + B, wrapped or clipped,
// loaded whenever the advance chain lets this stage move.
module affine_stage
    import affine_pkg::*;
#(
    parameter int                  W   = 16,
    parameter logic signed [W-1:0] K   = '0,
    parameter logic signed [W-1:0] B   = '0,
    parameter int                  SAT = SAT_WRAP
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                adv,
    input  logic                src_valid,
    input  logic signed [W-1:0] src_data,
    output logic                valid,
    output logic signed [W-1:0] data,
    output logic                ovf_pulse
);

    logic signed [2*W-1:0] prod;
    wide_t                 sum;

    assign prod = (2*W)'(src_data) * (2*W)'(K);
    assign sum  = wide_t'(prod) + wide_t'(B);

    // Invalid data may still load the register, so it must never flag overflow.
    assign ovf_pulse = adv & src_valid & out_of_range(sum, W);

    // NOTE: state registers use non-blocking assignments so every stage
    // samples its neighbour's pre-edge value and the shift is race-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (adv) begin
            valid <= src_valid;
            data  <= W'(sat_to_w(sum, W, SAT == SAT_CLIP));
        end
    end

endmodule

// File: rtl/affine_pipeline_stream.sv
// N-stage pipelined affine chain with collapsing valid/ready backpressure
// and a sticky overflow flag.
module affine_pipeline_stream
    import affine_pkg::*;
#(
    parameter int                    W       = 16,
    parameter int                    NSTAGES = 2,
    parameter logic [NSTAGES*W-1:0]  K_VEC   = {16'sd2, 16'sd3},
    parameter logic [NSTAGES*W-1:0]  B_VEC   = {16'sd7, 16'sd5},
    parameter int                    SAT     = SAT_WRAP
) (
    input logic                     clk,
    input logic                     rst,
    affine_pipeline_stream_if.slave bus
);

    logic [NSTAGES-1:0]  v;
    logic [NSTAGES-1:0]  adv;
    logic [NSTAGES-1:0]  ovf_pulse;
    logic signed [W-1:0] d [NSTAGES];
    logic                ovf_q;

    // A stage may move when it is empty or everything downstream of it moves,
    // i.e. out_ready is high or some later stage holds a bubble.
    always_comb begin
        logic chain;
        adv   = '0;
        // NOTE: combinational logic uses blocking assignments; the running
        // chain value must update immediately within the loop.
        chain = bus.out_ready;
        for (int i = NSTAGES - 1; i >= 0; i--) begin
            chain  = !v[i] | chain;
            adv[i] = chain;
        end
    end

    for (genvar i = 0; i < NSTAGES; i++) begin : g_stage
        logic                src_valid;
        logic signed [W-1:0] src_data;

        if (i == 0) begin : g_first
            assign src_valid = bus.in_valid;
            assign src_data  = bus.X;
        end else begin : g_next
            assign src_valid = v[i-1];
            assign src_data  = d[i-1];
        end

        affine_stage #(
            .W   (W),
            .K   (K_VEC[i*W +: W]),
            .B   (B_VEC[i*W +: W]),
            .SAT (SAT)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .adv       (adv[i]),
            .src_valid (src_valid),
            .src_data  (src_data),
            .valid     (v[i]),
            .data      (d[i]),
            .ovf_pulse (ovf_pulse[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst)             ovf_q <= 1'b0;
        else if (|ovf_pulse) ovf_q <= 1'b1;
    end

    assign bus.in_ready  = adv[0];
    assign bus.out_valid = v[NSTAGES-1];
    assign bus.Y         = d[NSTAGES-1];
    assign bus.ovf       = ovf_q;

endmodule
